pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1, meaning the number of cycles a load-use stall holds PC and IF/ID (range 1..7).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles IF/ID/EX are squashed after a redirect (range 1..7).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 is_stall  input  1  load-use hazard request from the hazard detector.
REQ-007 redirect  input  1  EX-stage PC redirect (pc_src != 00).
REQ-008 is_halt  input  1  halt instruction has reached MEM.
REQ-009 stack_overflow  input  1  stack overflow fault.
REQ-010 resume  input  1  single-cycle restart request, honoured only in HALT.
REQ-011 pc_en, if_en, id_en, ex_en, mem_en  output  1 each  stage register load enables.
REQ-012 if_flush, id_flush, ex_flush  output  1 each  insert a bubble (zero the instruction and controls) into IF/ID, ID/EX and EX/MEM respectively.
REQ-013 state  output  3  current state: RUN=0, STALL=1, FLUSH=2, HALT=3, FAULT=4.
REQ-014 halted, fault  output  1 each  status flags.
REQ-015 stall_count, flush_count  output  CNT_W each  performance counters.

Function
REQ-016 Enables and flushes SHALL be combinational functions of the current state and inputs (Mealy), so a request stalls or flushes in the same cycle it is raised.
REQ-017 RUN: all enables 1 and all flushes 0, unless one of the requests below is active.
REQ-018 Priority in every state except FAULT SHALL be: stack_overflow > is_halt > redirect > is_stall.
REQ-019 RUN with is_stall: pc_en=if_en=0, id_flush=1, other enables 1; remain counter loaded with STALL_CYCLES-1; go to STALL if STALL_CYCLES>1, else stay in RUN.
REQ-020 STALL: same outputs as REQ-019; the counter decrements each cycle; return to RUN after the cycle in which it reaches 0; is_stall is ignored while in STALL.
REQ-021 redirect in RUN or STALL: pc_en=1, if_flush=id_flush=1 that cycle; counter loaded with FLUSH_CYCLES-1; go to FLUSH if FLUSH_CYCLES>1. A pending stall SHALL be abandoned.
REQ-022 FLUSH: pc_en=1, if_flush=id_flush=1; counter decrements; return to RUN when it expires; is_stall and redirect are ignored.
REQ-023 is_halt in any non-FAULT state: in that cycle, pc_en=if_en=id_en=ex_en=0 and if_flush=id_flush=ex_flush=1 while mem_en=1, so older instructions retire; next state HALT.
REQ-024 HALT: all enables 0, halted=1; resume moves to FLUSH with the counter loaded with FLUSH_CYCLES-1, and halted clears on that edge.
REQ-025 stack_overflow in any state: all enables 0 in that cycle; next state FAULT.
REQ-026 FAULT SHALL be sticky: all enables 0, fault=1, and all inputs ignored until reset.
REQ-027 stall_count SHALL increment on every cycle in which the controller holds pc_en=0 for a stall; flush_count SHALL increment on every cycle in which if_flush=1.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 While rst=0, asynchronously: state=RUN, remain counter=0, halted=0, fault=0, and both counters=0.
REQ-030 A reset asserted mid-STALL, FLUSH, HALT or FAULT SHALL abandon that operation; the first cycle after release behaves as RUN.

Configuration
REQ-031 Macro PIPELINE_CONTROLLER_PERF_EN: when defined, the counters of REQ-027/028 SHALL be implemented.
REQ-032 When PIPELINE_CONTROLLER_PERF_EN is undefined, the stall_count and flush_count ports SHALL remain present, tied to 0, with no counter flops.

Verification
REQ-033 Stall test (STALL_CYCLES=1): pulse is_stall in RUN for 1 cycle -> pc_en=if_en=0 and id_flush=1 for exactly that cycle; stall_count=1; state stays 0.
REQ-034 Flush test (FLUSH_CYCLES=2): pulse redirect 1 cycle -> if_flush=id_flush=1 for 2 cycles with pc_en=1; state=2 for 1 cycle; flush_count=2.
REQ-035 Simultaneous test: is_stall and redirect high together -> flush behaviour only; stall_count unchanged.
REQ-036 Halt test: is_halt pulse -> that cycle mem_en=1 with ex_flush=1; then state=3 and halted=1; resume -> 2 flush cycles, then RUN.
REQ-037 Fault test: stack_overflow during FLUSH -> state=4 and fault=1; redirect and resume are ignored; rst=0 then 1 -> state=0 and fault=0.
REQ-038 Saturation test (CNT_W=4, PIPELINE_CONTROLLER_PERF_EN defined): 20 stall cycles -> stall_count=15; macro undefined -> stall_count=0.

Source files
------------

// File: rtl/pipeline_controller.sv
// pipeline_controller: hazard/redirect/halt/fault sequencing for a 5-stage pipe.
// Stage enables and bubble flushes are Mealy outputs of the current state and
// the request inputs. Status flags and performance counters are registered.
// Optional feature macro: PIPELINE_CONTROLLER_PERF_EN enables the saturating
// stall/flush counters; without it the counter ports read as zero.
module pipeline_controller #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_stall,
    input  logic             redirect,
    input  logic             is_halt,
    input  logic             stack_overflow,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_STALL = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         STALL_MULTI = (STALL_CYCLES > 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

    state_e     state_q, state_d;
    logic [2:0] remain_q, remain_d;
    logic       halted_q, halted_d;
    logic       fault_q, fault_d;

    // Next-state and Mealy enable/flush decode, priority overflow > halt > redirect > stall
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        pc_en    = 1'b1;
        if_en    = 1'b1;
        id_en    = 1'b1;
        ex_en    = 1'b1;
        mem_en   = 1'b1;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;

        if (state_q == ST_FAULT) begin
            // Sticky until reset: everything frozen, inputs ignored.
            {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
        end else if (stack_overflow) begin
            {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
            state_d  = ST_FAULT;
            remain_d = 3'd0;
            fault_d  = 1'b1;
            halted_d = 1'b0;
        end else if (is_halt) begin
            // Freeze the front of the pipe but let MEM/WB drain older work.
            {pc_en, if_en, id_en, ex_en} = 4'b0000;
            {if_flush, id_flush, ex_flush} = 3'b111;
            state_d  = ST_HALT;
            remain_d = 3'd0;
            halted_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (redirect) begin
                        // Redirect wins over a stall and abandons any pending one.
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                        remain_d = FLUSH_LOAD;
                        state_d  = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                    end else if (state_q == ST_STALL) begin
                        pc_en    = 1'b0;
                        if_en    = 1'b0;
                        id_flush = 1'b1;
                        if (remain_q <= 3'd1) begin
                            remain_d = 3'd0;
                            state_d  = ST_RUN;
                        end else begin
                            remain_d = remain_q - 3'd1;
                        end
                    end else if (is_stall) begin
                        pc_en    = 1'b0;
                        if_en    = 1'b0;
                        id_flush = 1'b1;
                        remain_d = STALL_LOAD;
                        state_d  = STALL_MULTI ? ST_STALL : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    if (remain_q <= 3'd1) begin
                        remain_d = 3'd0;
                        state_d  = ST_RUN;
                    end else begin
                        remain_d = remain_q - 3'd1;
                    end
                end
                ST_HALT: begin
                    {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
                    if (resume) begin
                        // The restart cycle already squashes IF/ID, so with the
                        // FLUSH state the front end sees FLUSH_CYCLES bubbles.
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                        remain_d = FLUSH_LOAD;
                        state_d  = ST_FLUSH;
                        halted_d = 1'b0;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                end
            endcase
        end
    end

    // Controller state and status flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            remain_q <= 3'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign state  = state_q;
    assign halted = halted_q;
    assign fault  = fault_q;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + one;
        end else begin
            return v;
        end
    endfunction

    // A stall cycle is the only case that holds PC while squashing just IF/ID.
    assign stall_evt_s = ~pc_en & id_flush & ~if_flush;

    // Saturating counter next values
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_evt_s);
        flush_cnt_d = sat_inc(flush_cnt_q, if_flush);
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = {CNT_W{1'b0}};
    assign flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: default-parameter instance plus a
// STALL_CYCLES=3 / CNT_W=4 instance for multi-cycle stall and saturation.
module tb_pipeline_controller;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic is_stall, redirect, is_halt, stack_overflow, resume;

    logic        a_pc, a_if, a_id, a_ex, a_mem, a_iff, a_idf, a_exf;
    logic [2:0]  a_state;
    logic        a_halted, a_fault;
    logic [15:0] a_scnt, a_fcnt;

    logic        b_pc, b_if, b_id, b_ex, b_mem, b_iff, b_idf, b_exf;
    logic [2:0]  b_state;
    logic        b_halted, b_fault;
    logic [3:0]  b_scnt, b_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_controller u_a (
        .clk(clk), .rst(rst), .is_stall(is_stall), .redirect(redirect),
        .is_halt(is_halt), .stack_overflow(stack_overflow), .resume(resume),
        .pc_en(a_pc), .if_en(a_if), .id_en(a_id), .ex_en(a_ex), .mem_en(a_mem),
        .if_flush(a_iff), .id_flush(a_idf), .ex_flush(a_exf),
        .state(a_state), .halted(a_halted), .fault(a_fault),
        .stall_count(a_scnt), .flush_count(a_fcnt)
    );

    pipeline_controller #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .is_stall(is_stall), .redirect(redirect),
        .is_halt(is_halt), .stack_overflow(stack_overflow), .resume(resume),
        .pc_en(b_pc), .if_en(b_if), .id_en(b_id), .ex_en(b_ex), .mem_en(b_mem),
        .if_flush(b_iff), .id_flush(b_idf), .ex_flush(b_exf),
        .state(b_state), .halted(b_halted), .fault(b_fault),
        .stall_count(b_scnt), .flush_count(b_fcnt)
    );

    // Packed {pc,if,id,ex,mem,if_flush,id_flush,ex_flush}
    wire [7:0] a_vec = {a_pc, a_if, a_id, a_ex, a_mem, a_iff, a_idf, a_exf};
    wire [7:0] b_vec = {b_pc, b_if, b_id, b_ex, b_mem, b_iff, b_idf, b_exf};

    localparam logic [7:0] V_RUN   = 8'b11111_000;
    localparam logic [7:0] V_STALL = 8'b00111_010;
    localparam logic [7:0] V_FLUSH = 8'b11111_110;
    localparam logic [7:0] V_HALTQ = 8'b00001_111;
    localparam logic [7:0] V_FROZE = 8'b00000_000;
    localparam logic [7:0] V_RESUM = 8'b00000_110;

    function automatic logic [31:0] pe(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic hl, input logic ov, input logic rs);
        @(negedge clk);
        is_stall = st; redirect = rd; is_halt = hl; stack_overflow = ov; resume = rs;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        is_stall = 1'b0; redirect = 1'b0; is_halt = 1'b0; stack_overflow = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_halted", 32'(a_halted), 32'd0);
        chk("rst_fault", 32'(a_fault), 32'd0);
        chk("rst_scnt", 32'(a_scnt), 32'd0);
        chk("rst_fcnt", 32'(a_fcnt), 32'd0);
        chk("rst_vec", 32'(a_vec), 32'(V_RUN));
        @(negedge clk); rst = 1'b1;

        // Idle RUN
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_vec", 32'(a_vec), 32'(V_RUN));

        // Stall: single-cycle on A, three-cycle on B
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_vec_a", 32'(a_vec), 32'(V_STALL));
        chk("stall_vec_b", 32'(b_vec), 32'(V_STALL));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_done_vec_a", 32'(a_vec), 32'(V_RUN));
        chk("stall_state_a", 32'(a_state), 32'd0);
        chk("stall_cnt_a", 32'(a_scnt), pe(1));
        chk("stall2_state_b", 32'(b_state), 32'd1);
        chk("stall2_vec_b", 32'(b_vec), 32'(V_STALL));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall3_state_b", 32'(b_state), 32'd1);
        chk("stall3_vec_b", 32'(b_vec), 32'(V_STALL));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_end_state_b", 32'(b_state), 32'd0);
        chk("stall_end_vec_b", 32'(b_vec), 32'(V_RUN));
        chk("stall_cnt_b", 32'(b_scnt), pe(3));
        chk("stall_cnt_a_hold", 32'(a_scnt), pe(1));

        // Redirect flush
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush1_vec", 32'(a_vec), 32'(V_FLUSH));
        chk("flush1_state", 32'(a_state), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush2_vec", 32'(a_vec), 32'(V_FLUSH));
        chk("flush2_state", 32'(a_state), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_end_vec", 32'(a_vec), 32'(V_RUN));
        chk("flush_end_state", 32'(a_state), 32'd0);
        chk("flush_cnt", 32'(a_fcnt), pe(2));

        // Stall and redirect together: flush only
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_vec", 32'(a_vec), 32'(V_FLUSH));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("simul_state", 32'(a_state), 32'd2);
        chk("simul_scnt_a", 32'(a_scnt), pe(1));
        chk("simul_scnt_b", 32'(b_scnt), pe(3));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("simul_fcnt", 32'(a_fcnt), pe(4));

        // Halt and resume
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_vec", 32'(a_vec), 32'(V_HALTQ));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_state", 32'(a_state), 32'd3);
        chk("halt_flag", 32'(a_halted), 32'd1);
        chk("halt_vec_frozen", 32'(a_vec), 32'(V_FROZE));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_vec", 32'(a_vec), 32'(V_RESUM));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_state", 32'(a_state), 32'd2);
        chk("resume_halted", 32'(a_halted), 32'd0);
        chk("resume_flush_vec", 32'(a_vec), 32'(V_FLUSH));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_run", 32'(a_state), 32'd0);
        chk("resume_fcnt", 32'(a_fcnt), pe(7));

        // Fault during FLUSH, sticky until reset
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_state_flush", 32'(a_state), 32'd2);
        chk("ovf_vec", 32'(a_vec), 32'(V_FROZE));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fault_state", 32'(a_state), 32'd4);
        chk("fault_flag", 32'(a_fault), 32'd1);
        chk("fault_vec", 32'(a_vec), 32'(V_FROZE));
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("fault_sticky", 32'(a_state), 32'd4);
        chk("fault_fcnt", 32'(a_fcnt), pe(8));
        @(negedge clk); rst = 1'b0; #1;
        chk("fault_rst_state", 32'(a_state), 32'd0);
        chk("fault_rst_flag", 32'(a_fault), 32'd0);
        chk("fault_rst_fcnt", 32'(a_fcnt), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_vec", 32'(a_vec), 32'(V_RUN));
        chk("post_rst_state", 32'(a_state), 32'd0);

        // Saturation: 20 stall cycles
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_scnt_a", 32'(a_scnt), pe(20));
        chk("sat_scnt_b", 32'(b_scnt), pe(15));
        chk("sat_fcnt_b", 32'(b_fcnt), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
